ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the idle clk cycles after which a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8, giving the ASCII output buffer depth (power of two).
REQ-003 The module SHALL have port clk, input, 1 bit: single system clock (CLOCK_50 domain); all logic on its rising edge.
REQ-004 The module SHALL have port clrn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous.
REQ-006 The module SHALL have port ps2_data, input, 1 bit: raw PS/2 data from the keyboard, asynchronous.
REQ-007 The module SHALL have port key_ascii, output, 8 bits: ASCII code at the FIFO head.
REQ-008 The module SHALL have port key_valid, output, 1 bit: key_ascii holds an unread key.
REQ-009 The module SHALL have port key_ready, input, 1 bit: the consumer (game logic) accepts the head.
REQ-010 The module SHALL have port key_down, output, 1 bit: a recognised key is currently held.
REQ-011 The module SHALL have port scan_code, output, 8 bits: last valid received byte, for HEX display.
REQ-012 The module SHALL have port overflow, output, 1 bit: sticky flag, a key was dropped because the FIFO was full.
REQ-013 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.

Function
REQ-014 The module SHALL pass ps2_clk and ps2_data through 3-flop synchronisers and SHALL sample data on each detected falling edge of the synchronised ps2_clk.
REQ-015 The receiver SHALL collect 11 bits per frame: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-016 A frame with a bad start, parity or stop bit SHALL be discarded, SHALL pulse frame_err for exactly one cycle, and SHALL leave the decode state unchanged.
REQ-017 If TIMEOUT_CYCLES cycles pass without a falling edge while 1-10 bits are held, the bit counter SHALL return to 0 with no frame_err pulse.
REQ-018 Decoder states SHALL be IDLE, EXT (after 0xE0), BRK (after 0xF0) and EXT_BRK (0xE0 then 0xF0).
REQ-019 Any byte completing an E0-prefixed sequence SHALL return the decoder to IDLE and SHALL push nothing.
REQ-020 A break sequence (F0 xx) SHALL clear key_down when xx equals the held make code and SHALL push nothing.
REQ-021 A make code SHALL be pushed only if it maps to ASCII: 0x15-0x4D letter codes to 'A'-'Z' uppercase, digit row to '0'-'9', 0x29 to 0x20, 0x5A to 0x0D; unmapped codes SHALL be ignored.
REQ-022 A make code equal to the currently held code (typematic repeat) SHALL NOT be pushed again.
REQ-023 A different make code while a key is held SHALL be pushed and SHALL become the held code.
REQ-024 Timing: if the stop bit is accepted in cycle T, scan_code SHALL update at T+1, the FIFO push SHALL occur at T+1, and key_valid SHALL be high from T+2 when the FIFO was empty.
REQ-025 Handshake: the head is popped on a cycle with key_valid and key_ready both high; key_ascii SHALL stay stable while key_valid is high and key_ready is low.
REQ-026 A push into a full FIFO SHALL be dropped and SHALL set overflow; a push and a pop in the same cycle while full SHALL both succeed and SHALL NOT set overflow.
REQ-027 The FIFO SHALL preserve arrival order, and its pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 While clrn=0 at a clk edge, the module SHALL set key_ascii=0x00, key_valid=0, key_down=0, scan_code=0x00, overflow=0, frame_err=0, FIFO empty, bit counter 0, timeout counter 0 and decoder IDLE.
REQ-029 A reset arriving mid-frame SHALL abandon that frame, and the receiver SHALL resynchronise on the next start bit after reset.

Structure
REQ-030 A shared package ps2_pkg SHALL hold the constants PS2_EXT=0xE0, PS2_BRK=0xF0 and ASCII_ENTER/ASCII_SPACE, plus the decoder state enumeration.
REQ-031 The combinational scan-code-to-ASCII table SHALL be a separate sub-module ps2_scan2ascii with an 8-bit code input, an 8-bit ascii output and a hit output.

Verification
REQ-032 Frame 0x1C -> key_valid high 2 cycles after the stop bit, key_ascii=0x41, key_down=1.
REQ-033 Frames 1C,1C,1C,F0,1C -> exactly one 0x41 pushed, key_down=0 after the final byte, scan_code=0x1C.
REQ-034 Frame 0x1C with the parity bit inverted -> one-cycle frame_err pulse, key_valid stays 0.
REQ-035 Keys 16,1E,26,25,2E,36,3D,3E,46 (each followed by F0 xx) with key_ready=0 -> overflow=1, and popping returns 0x31..0x38 in order, then key_valid=0.
REQ-036 5 bits, then 2 ms idle, then full frame 0x29 -> no frame_err, key_ascii=0x20.
REQ-037 E0 75 then 0x5A -> only 0x0D pushed; clrn low mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 protocol constants and decoder state encoding
package ps2_pkg;
  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] ASCII_ENTER = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_e;
endpackage

// File: rtl/ps2_scan2ascii.sv
// ps2_scan2ascii: set-2 make code to uppercase ASCII lookup with hit flag
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o,
  output logic       hit_o
);
  // table lookup; anything not listed is a miss
  always_comb begin
    ascii_o = 8'h00;
    hit_o   = 1'b1;
    case (code_i)
      8'h1C: ascii_o = "A";
      8'h32: ascii_o = "B";
      8'h21: ascii_o = "C";
      8'h23: ascii_o = "D";
      8'h24: ascii_o = "E";
      8'h2B: ascii_o = "F";
      8'h34: ascii_o = "G";
      8'h33: ascii_o = "H";
      8'h43: ascii_o = "I";
      8'h3B: ascii_o = "J";
      8'h42: ascii_o = "K";
      8'h4B: ascii_o = "L";
      8'h3A: ascii_o = "M";
      8'h31: ascii_o = "N";
      8'h44: ascii_o = "O";
      8'h4D: ascii_o = "P";
      8'h15: ascii_o = "Q";
      8'h2D: ascii_o = "R";
      8'h1B: ascii_o = "S";
      8'h2C: ascii_o = "T";
      8'h3C: ascii_o = "U";
      8'h2A: ascii_o = "V";
      8'h1D: ascii_o = "W";
      8'h22: ascii_o = "X";
      8'h35: ascii_o = "Y";
      8'h1A: ascii_o = "Z";
      8'h45: ascii_o = "0";
      8'h16: ascii_o = "1";
      8'h1E: ascii_o = "2";
      8'h26: ascii_o = "3";
      8'h25: ascii_o = "4";
      8'h2E: ascii_o = "5";
      8'h36: ascii_o = "6";
      8'h3D: ascii_o = "7";
      8'h3E: ascii_o = "8";
      8'h46: ascii_o = "9";
      8'h29: ascii_o = ASCII_SPACE;
      8'h5A: ascii_o = ASCII_ENTER;
      default: hit_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver, make/break decoder and ASCII key FIFO
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic [7:0] scan_code,
  output logic       overflow,
  output logic       frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0] pclk_q, pdat_q;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] scan_q, held_q, held_d, ascii;
  logic rx_ok_q, ferr_q, down_q, down_d, ovf_q, hit, push, pop, full, wr_en;
  logic fall, last, frame_ok, tmo_hit, bit_in;
  dec_state_e state_q, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  // idle-high synchronisers; the oldest clock stage is the edge-detect history
  always_ff @(posedge clk) begin
    if (!clrn) begin
      pclk_q <= 3'b111;
      pdat_q <= 3'b111;
    end else begin
      pclk_q <= {pclk_q[1:0], ps2_clk};
      pdat_q <= {pdat_q[1:0], ps2_data};
    end
  end
  assign fall     = pclk_q[2] & ~pclk_q[1];
  assign bit_in   = pdat_q[2];
  assign last     = fall & (cnt_q == 4'd10);
  assign frame_ok = ~sh_q[0] & (^sh_q[9:1]) & bit_in;
  assign tmo_hit  = (cnt_q != 4'd0) & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  // bit counter, shift register and inactivity timer
  always_comb begin
    cnt_d = fall ? (last ? 4'd0 : cnt_q + 4'd1) : (tmo_hit ? 4'd0 : cnt_q);
    sh_d  = fall ? {bit_in, sh_q[9:1]} : sh_q;
    tmo_d = (fall | tmo_hit | cnt_q == 4'd0) ? '0 : tmo_q + TW'(1);
  end
  // receiver state plus registered frame verdict and accepted byte
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      tmo_q   <= '0;
      rx_ok_q <= 1'b0;
      ferr_q  <= 1'b0;
      scan_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tmo_q   <= tmo_d;
      rx_ok_q <= last & frame_ok;
      ferr_q  <= last & ~frame_ok;
      scan_q  <= (last & frame_ok) ? sh_q[8:1] : scan_q;
    end
  end
  ps2_scan2ascii u_map (.code_i(scan_q), .ascii_o(ascii), .hit_o(hit));
  // decoder state register with held-key tracking
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      held_q  <= '0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      down_q  <= down_d;
    end
  end
  // prefix bytes steer the state; every other byte ends the sequence
  always_comb begin
    state_d = !rx_ok_q ? state_q :
              state_q == IDLE ? (scan_q == PS2_EXT ? EXT : scan_q == PS2_BRK ? BRK : IDLE) :
              (state_q == EXT && scan_q == PS2_BRK) ? EXT_BRK : IDLE;
  end
  // plain make codes push unless repeating the held key; breaks release it
  always_comb begin
    push   = rx_ok_q & (state_q == IDLE) & (scan_q != PS2_EXT) & (scan_q != PS2_BRK) &
             hit & (~down_q | scan_q != held_q);
    held_d = push ? scan_q : held_q;
    down_d = push ? 1'b1 :
             (rx_ok_q & state_q == BRK & down_q & scan_q == held_q) ? 1'b0 : down_q;
  end
  assign key_valid = wr_q != rd_q;
  assign full      = (wr_q[AW] != rd_q[AW]) & (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop       = key_valid & key_ready;
  assign wr_en     = push & (~full | pop);
  // FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_en ? wr_q + 1'b1 : wr_q;
      rd_q  <= pop ? rd_q + 1'b1 : rd_q;
      ovf_q <= ovf_q | (push & full & ~pop);
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (clrn && wr_en) mem[wr_q[AW-1:0]] <= ascii;
  end
  assign key_ascii = key_valid ? mem[rd_q[AW-1:0]] : 8'h00;
  assign key_down  = down_q;
  assign scan_code = scan_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames with a scoreboard of expected ASCII keys
module tb_ps2_key_decoder;
  localparam int H = 20;
  logic clk = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, key_ready = 0;
  logic [7:0] key_ascii, scan_code;
  logic key_valid, key_down, overflow, frame_err;
  int checks = 0, errors = 0, fe_cyc = 0, fe0 = 0;
  logic [7:0] sb[$];
  logic [7:0] keys [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic ovf_exp;
  bit found;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(400), .FIFO_DEPTH(8)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_ascii(key_ascii), .key_valid(key_valid), .key_ready(key_ready),
    .key_down(key_down), .scan_code(scan_code), .overflow(overflow), .frame_err(frame_err)
  );

  always @(negedge clk) if (frame_err) fe_cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 0;
    repeat (H) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(1'b1);
    repeat (60) @(negedge clk);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
    ps2_data = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      key_ready = 0;
      if (key_valid) begin
        if (sb.size() == 0) chk("extra_key", 32'(key_valid), 32'd0);
        else chk("key_ascii", 32'(key_ascii), 32'(sb.pop_front()));
        key_ready = 1;
      end else if (sb.size() == 0) break;
    end
    key_ready = 0;
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ascii", 32'(key_ascii), 32'h00);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_down", 32'(key_down), 32'd0);
    chk("rst_scan", 32'(scan_code), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    clrn = 1;
    repeat (10) @(negedge clk);

    sb.push_back(8'h41);
    fork
      send_frame(8'h1C, 0);
      begin
        found = 0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (scan_code == 8'h1C) begin found = 1; break; end
        end
        chk("stop_seen", 32'(found), 32'd1);
        chk("valid_T1", 32'(key_valid), 32'd0);
        @(negedge clk);
        chk("valid_T2", 32'(key_valid), 32'd1);
      end
    join
    chk("head_A", 32'(key_ascii), 32'h41);
    chk("down_A", 32'(key_down), 32'd1);
    send_frame(8'h1C, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain();
    chk("down_after_brk", 32'(key_down), 32'd0);
    chk("scan_after_brk", 32'(scan_code), 32'h1C);

    fe0 = fe_cyc;
    send_frame(8'h1C, 1);
    chk("ferr_pulse", 32'(fe_cyc - fe0), 32'd1);
    chk("ferr_valid", 32'(key_valid), 32'd0);
    chk("ferr_down", 32'(key_down), 32'd0);
    chk("ferr_scan", 32'(scan_code), 32'h1C);

    ovf_exp = 0;
    for (int k = 0; k < 9; k++) begin
      send_frame(keys[k], 0);
      if (sb.size() < 8) sb.push_back(8'h31 + 8'(k));
      else ovf_exp = 1;
      send_frame(8'hF0, 0);
      send_frame(keys[k], 0);
    end
    chk("overflow", 32'(overflow), 32'(ovf_exp));
    chk("head_stable", 32'(key_ascii), 32'h31);
    drain();

    fe0 = fe_cyc;
    send_bits(5);
    repeat (1000) @(negedge clk);
    sb.push_back(8'h20);
    send_frame(8'h29, 0);
    chk("tmo_no_ferr", 32'(fe_cyc - fe0), 32'd0);
    chk("tmo_scan", 32'(scan_code), 32'h29);
    drain();

    sb.push_back(8'h0D);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    send_frame(8'h5A, 0);
    drain();
    chk("enter_down", 32'(key_down), 32'd1);
    chk("enter_scan", 32'(scan_code), 32'h5A);

    send_bits(5);
    clrn = 0;
    @(negedge clk);
    chk("mid_ascii", 32'(key_ascii), 32'h00);
    chk("mid_valid", 32'(key_valid), 32'd0);
    chk("mid_down", 32'(key_down), 32'd0);
    chk("mid_scan", 32'(scan_code), 32'h00);
    chk("mid_ovf", 32'(overflow), 32'd0);
    chk("mid_ferr", 32'(frame_err), 32'd0);
    clrn = 1;
    repeat (50) @(negedge clk);
    sb.push_back(8'h41);
    send_frame(8'h1C, 0);
    drain();
    chk("resync_down", 32'(key_down), 32'd1);
    chk("resync_scan", 32'(scan_code), 32'h1C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
